zifi_uart_ctrl: RTL and testbench
=================================

Name: zifi_uart_ctrl

Overview:
- Buffering and sequencing controller between the ZiFi CPU register interface and the uart transmitter/receiver pair.
- Owns a TX FIFO and an RX FIFO.
- Drives the UART txbegin/txbusy handshake to drain the TX FIFO.
- Captures received bytes, using the data_read handshake so the receiver holds rts asserted while the RX FIFO has no space.
- Exposes FIFO levels and sticky error flags to the CPU.

Parameters:
- TX_AW, 4, TX FIFO address width (depth 2^TX_AW = 16).
- RX_AW, 4, RX FIFO address width (depth 16).
- RX_HIWATER, 12, rx_count level at or above which rx_hiwater is asserted.

Ports:
- clk_bus  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_data  in  8  byte to push into TX FIFO.
- wr_stb  in  1  one-cycle push strobe.
- rd_stb  in  1  one-cycle pop strobe for RX FIFO.
- rd_data  out  8  RX FIFO head (show-ahead); 8'hFF when empty.
- tx_clr  in  1  flush TX FIFO, clear tx_ovf.
- rx_clr  in  1  flush RX FIFO, clear rx_unf.
- tx_count  out  TX_AW+1  bytes in TX FIFO.
- rx_count  out  RX_AW+1  bytes in RX FIFO.
- tx_ovf  out  1  sticky: wr_stb while TX FIFO full.
- rx_unf  out  1  sticky: rd_stb while RX FIFO empty.
- rx_hiwater  out  1  rx_count >= RX_HIWATER.
- tx_idle  out  1  TX FIFO empty and TX FSM in T_IDLE and !u_txbusy.
- u_txdata  out  8  byte to transmitter, registered.
- u_txbegin  out  1  transmit start pulse, registered.
- u_txbusy  in  1  transmitter busy.
- u_rxdata  in  8  received byte, valid while u_rxrecv=1.
- u_rxrecv  in  1  one-cycle byte-received pulse.
- u_data_read  out  1  one-cycle acknowledge releasing the receiver.

Behaviour:
- Reset values:
  - Counts 0, flags 0, u_txbegin 0, u_txdata 8'h00.
  - u_data_read 0, except it pulses once in the first cycle after rst deasserts. This releases a receiver left stranded in its wait state.
  - FSMs go to T_IDLE / R_IDLE.
- FIFOs: registered pointers and counts, wrap modulo depth.
  - Push and pop in the same cycle: both execute, count unchanged. Also true when full (pop frees the slot) or empty (push writes, pop ignored).
  - Push when full without a pop: dropped, tx_ovf set.
  - Pop when empty: ignored, rx_unf set.
  - Flush (tx_clr/rx_clr) has priority over push/pop in the same cycle; counts become 0 next cycle.
- TX FSM:
  - T_IDLE: if tx_count!=0 and !u_txbusy, load u_txdata from head, pop TX FIFO, assert u_txbegin for exactly one cycle -> T_START.
  - T_START: u_txbegin=0; on u_txbusy=1 -> T_BUSY. If u_txbusy stays 0 for 4 cycles -> T_IDLE; the byte is lost, no retry.
  - T_BUSY: on u_txbusy=0 -> T_IDLE.
  - Latency: wr_stb in cycle N into empty FIFO with idle UART -> u_txbegin high in cycle N+2. Back-to-back bytes: next u_txbegin 1 cycle after u_txbusy falls.
  - tx_clr never aborts a byte already handed to the UART.
  - The TX FSM never raises u_txbegin while u_txbusy=1.
- RX FSM:
  - R_IDLE: on u_rxrecv, capture u_rxdata into hold register.
    - If RX FIFO not full, or rd_stb pops the same cycle: push, pulse u_data_read next cycle -> R_ACK.
    - Else -> R_HOLD.
  - R_HOLD: held byte waits; the UART keeps rts asserted. When count < depth, push hold, pulse u_data_read -> R_ACK.
  - R_ACK: u_data_read=0 -> R_IDLE.
  - Latency: u_rxrecv in cycle M (FIFO not full) -> rx_count incremented and u_data_read=1 in cycle M+1.
  - rx_clr during R_HOLD flushes the FIFO; the held byte is pushed the following cycle.
  - u_rxrecv outside R_IDLE is ignored; this cannot occur with a compliant receiver.
- Reset mid-operation: all controller state is re-initialised immediately. The UART itself is unaffected; the TX FSM waits for u_txbusy=0 before the next start.

Test Plan:
- Reset, then wr_stb with 8'h55, UART model with txbusy high 10 cycles -> u_txbegin single pulse 2 cycles after write, u_txdata=8'h55, tx_count 1->0, tx_idle=1 after txbusy falls.
- 17 consecutive writes 8'h00..8'h10 with UART stalled busy -> tx_count=16, tx_ovf=1, bytes 8'h00..8'h0F later transmitted in order; tx_clr clears tx_ovf.
- 3 u_rxrecv pulses carrying 8'hA1, 8'hA2, 8'hA3 -> u_data_read pulse 1 cycle after each, rx_count=3, rd_data=8'hA1; three rd_stb return A1, A2, A3, then rd_data=8'hFF; a fourth rd_stb sets rx_unf.
- Fill RX FIFO to 16 bytes, send 17th byte 8'h77 -> rx_hiwater=1, no u_data_read until rd_stb; u_data_read pulses on the cycle after the pop cycle, and 8'h77 ends up last in the FIFO.
- Same-cycle wr_stb and TX pop with tx_count=16 -> count stays 16, no tx_ovf.
- Assert rst while in T_BUSY and R_HOLD -> all outputs at reset values next cycle, one u_data_read pulse after release, no u_txbegin while u_txbusy=1.

Source files
------------

// File: rtl/zifi_uart_ctrl.sv
// zifi_uart_ctrl: TX/RX FIFO buffering and UART handshake sequencing for the ZiFi CPU
module zifi_uart_ctrl #(
    parameter int TX_AW      = 4,
    parameter int RX_AW      = 4,
    parameter int RX_HIWATER = 12
) (
    input  logic             clk_bus,
    input  logic             rst,
    input  logic [7:0]       wr_data,
    input  logic             wr_stb,
    input  logic             rd_stb,
    output logic [7:0]       rd_data,
    input  logic             tx_clr,
    input  logic             rx_clr,
    output logic [TX_AW:0]   tx_count,
    output logic [RX_AW:0]   rx_count,
    output logic             tx_ovf,
    output logic             rx_unf,
    output logic             rx_hiwater,
    output logic             tx_idle,
    output logic [7:0]       u_txdata,
    output logic             u_txbegin,
    input  logic             u_txbusy,
    input  logic [7:0]       u_rxdata,
    input  logic             u_rxrecv,
    output logic             u_data_read
);
    localparam logic [TX_AW:0] TX_DEPTH = {1'b1, {TX_AW{1'b0}}};
    localparam logic [RX_AW:0] RX_DEPTH = {1'b1, {RX_AW{1'b0}}};
    typedef enum logic [1:0] {T_IDLE, T_START, T_BUSY} tx_st_e;
    typedef enum logic [1:0] {R_IDLE, R_HOLD, R_ACK} rx_st_e;
    logic [7:0]       tx_mem [2**TX_AW];
    logic [TX_AW-1:0] tx_wp_q, tx_rp_q;
    logic [TX_AW:0]   tx_cnt_q;
    logic             tx_ovf_q, tx_push, tx_pop;
    tx_st_e           tx_st_q, tx_st_d;
    logic [1:0]       tmo_q, tmo_d;
    logic [7:0]       txdata_q, txdata_d;
    logic             txbegin_q, txbegin_d;
    logic [7:0]       rx_mem [2**RX_AW];
    logic [RX_AW-1:0] rx_wp_q, rx_rp_q;
    logic [RX_AW:0]   rx_cnt_q;
    logic             rx_unf_q, rx_push, rx_pop, rx_ok;
    rx_st_e           rx_st_q, rx_st_d;
    logic [7:0]       hold_q, hold_d, rx_wdata;
    logic             drd_q, drd_d, init_q;

    assign tx_push  = wr_stb && (tx_cnt_q != TX_DEPTH || tx_pop);
    assign rx_pop   = rd_stb && rx_cnt_q != '0;
    assign rx_ok    = !rx_clr && (rx_cnt_q != RX_DEPTH || rd_stb);
    assign rx_wdata = rx_st_q == R_HOLD ? hold_q : u_rxdata;

    // TX FIFO pointers/count: flush wins, a push into a full FIFO survives only alongside a pop
    always_ff @(posedge clk_bus) begin
        if (rst || tx_clr) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + TX_AW'(1);
            if (tx_pop) tx_rp_q <= tx_rp_q + TX_AW'(1);
            tx_cnt_q <= tx_cnt_q + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
            if (wr_stb && !tx_push) tx_ovf_q <= 1'b1;
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk_bus) begin
        if (tx_push && !tx_clr) tx_mem[tx_wp_q] <= wr_data;
    end

    // TX state and registered transmitter outputs
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            tx_st_q   <= T_IDLE;
            tmo_q     <= '0;
            txdata_q  <= '0;
            txbegin_q <= 1'b0;
        end else begin
            tx_st_q   <= tx_st_d;
            tmo_q     <= tmo_d;
            txdata_q  <= txdata_d;
            txbegin_q <= txbegin_d;
        end
    end

    // TX next state: start from idle, or straight from busy as soon as the transmitter frees up
    always_comb begin
        tx_pop  = tx_cnt_q != '0 && !u_txbusy && tx_st_q != T_START;
        tx_st_d = tx_pop ? T_START :
                  tx_st_q == T_START ? (u_txbusy ? T_BUSY : (tmo_q == 2'd3 ? T_IDLE : T_START)) :
                  (tx_st_q == T_BUSY && u_txbusy) ? T_BUSY : T_IDLE;
    end

    // TX outputs: one-cycle start with the popped head byte, start-ack timeout counter
    always_comb begin
        txbegin_d = tx_pop;
        txdata_d  = tx_pop ? tx_mem[tx_rp_q] : txdata_q;
        tmo_d     = tx_st_q == T_START ? tmo_q + 2'd1 : 2'd0;
    end

    // RX FIFO pointers/count: flush wins, popping an empty FIFO only flags underflow
    always_ff @(posedge clk_bus) begin
        if (rst || rx_clr) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            rx_unf_q <= 1'b0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + RX_AW'(1);
            if (rx_pop) rx_rp_q <= rx_rp_q + RX_AW'(1);
            rx_cnt_q <= rx_cnt_q + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
            if (rd_stb && !rx_pop) rx_unf_q <= 1'b1;
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk_bus) begin
        if (rx_push) rx_mem[rx_wp_q] <= rx_wdata;
    end

    // RX state, hold register and acknowledge; init_q releases a receiver stranded across reset
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            rx_st_q <= R_IDLE;
            hold_q  <= '0;
            drd_q   <= 1'b0;
            init_q  <= 1'b1;
        end else begin
            rx_st_q <= rx_st_d;
            hold_q  <= hold_d;
            drd_q   <= drd_d;
            init_q  <= 1'b0;
        end
    end

    // RX next state: push when there is room (or a same-cycle pop), otherwise hold the byte
    always_comb begin
        rx_push = rx_ok && (rx_st_q == R_HOLD || (rx_st_q == R_IDLE && u_rxrecv));
        rx_st_d = rx_push ? R_ACK :
                  ((rx_st_q == R_IDLE && u_rxrecv) || rx_st_q == R_HOLD) ? R_HOLD : R_IDLE;
    end

    // RX outputs: capture on receive, acknowledge the cycle after the push
    always_comb begin
        hold_d = (rx_st_q == R_IDLE && u_rxrecv) ? u_rxdata : hold_q;
        drd_d  = rx_push || init_q;
    end

    assign rd_data     = rx_cnt_q == '0 ? 8'hFF : rx_mem[rx_rp_q];
    assign tx_count    = tx_cnt_q;
    assign rx_count    = rx_cnt_q;
    assign tx_ovf      = tx_ovf_q;
    assign rx_unf      = rx_unf_q;
    assign rx_hiwater  = rx_cnt_q >= (RX_AW+1)'(RX_HIWATER);
    assign tx_idle     = tx_cnt_q == '0 && tx_st_q == T_IDLE && !u_txbusy;
    assign u_txdata    = txdata_q;
    assign u_txbegin   = txbegin_q;
    assign u_data_read = drd_q;
endmodule

// File: tb/tb_zifi_uart_ctrl.sv
// tb_zifi_uart_ctrl: directed and randomized checks of zifi_uart_ctrl against queue models
module tb_zifi_uart_ctrl;
    logic       clk_bus = 1'b0, rst = 1'b1;
    logic [7:0] wr_data = '0, u_rxdata = '0;
    logic       wr_stb = 1'b0, rd_stb = 1'b0, tx_clr = 1'b0, rx_clr = 1'b0, u_rxrecv = 1'b0;
    logic       u_txbusy = 1'b0;
    logic [7:0] rd_data, u_txdata;
    logic [4:0] tx_count, rx_count;
    logic       tx_ovf, rx_unf, rx_hiwater, tx_idle, u_txbegin, u_data_read;
    int         chk_n = 0, pass_n = 0;
    int         busy_len = 9, busy_left = 0, k;
    bit         stall = 1'b0, tx_dead = 1'b0;
    logic [7:0] txq[$], exp_q[$], rxm[$], b;

    zifi_uart_ctrl dut (
        .clk_bus(clk_bus), .rst(rst), .wr_data(wr_data), .wr_stb(wr_stb), .rd_stb(rd_stb),
        .rd_data(rd_data), .tx_clr(tx_clr), .rx_clr(rx_clr), .tx_count(tx_count),
        .rx_count(rx_count), .tx_ovf(tx_ovf), .rx_unf(rx_unf), .rx_hiwater(rx_hiwater),
        .tx_idle(tx_idle), .u_txdata(u_txdata), .u_txbegin(u_txbegin), .u_txbusy(u_txbusy),
        .u_rxdata(u_rxdata), .u_rxrecv(u_rxrecv), .u_data_read(u_data_read)
    );

    always #5 clk_bus = ~clk_bus;

    task automatic tick;
        @(posedge clk_bus);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        for (int i = 0; i < lim && !tx_idle; i++) tick;
        check(tag, 32'(tx_idle), 1);
    endtask

    task automatic wait_begin(input string tag);
        for (int i = 0; i < 10 && !u_txbegin; i++) tick;
        check(tag, 32'(u_txbegin), 1);
    endtask

    task automatic write(input logic [7:0] d);
        wr_data = d;
        wr_stb = 1'b1;
        tick;
        wr_stb = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        u_rxdata = d;
        u_rxrecv = 1'b1;
        tick;
        u_rxrecv = 1'b0;
    endtask

    task automatic pop(input string tag);
        check(tag, 32'(rd_data), 32'(rxm.pop_front()));
        rd_stb = 1'b1;
        tick;
        rd_stb = 1'b0;
    endtask

    task automatic cmp_txq(input string tag);
        check({tag, "_n"}, 32'(txq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < txq.size(); i++) check(tag, 32'(txq[i]), 32'(exp_q[i]));
    endtask

    // transmitter model: busy the cycle after a start, held high while stalled
    always @(posedge clk_bus) begin
        if (stall) u_txbusy <= 1'b1;
        else if (u_txbegin && !tx_dead) begin
            u_txbusy  <= 1'b1;
            busy_left <= busy_len;
        end else if (busy_left != 0) busy_left <= busy_left - 1;
        else u_txbusy <= 1'b0;
    end

    // every start must find the transmitter free; record what was sent
    always @(negedge clk_bus) begin
        if (u_txbegin === 1'b1) begin
            check("begin_while_busy", 32'(u_txbusy), 0);
            txq.push_back(u_txdata);
        end
    end

    initial begin
        repeat (2) tick;
        check("rst_txc", 32'(tx_count), 0);
        check("rst_rxc", 32'(rx_count), 0);
        check("rst_flags", 32'({tx_ovf, rx_unf, rx_hiwater, u_txbegin, u_data_read}), 0);
        check("rst_txdata", 32'(u_txdata), 0);
        check("rst_rddata", 32'(rd_data), 'hFF);
        rst = 1'b0;
        tick;
        check("rst_drd_pulse", 32'(u_data_read), 1);
        tick;
        check("rst_drd_end", 32'(u_data_read), 0);
        check("rst_idle", 32'(tx_idle), 1);

        // single byte, latency N+2
        wr_data = 'h55;
        wr_stb = 1'b1;
        tick;
        wr_stb = 1'b0;
        check("t1_cnt1", 32'(tx_count), 1);
        check("t1_beg_n1", 32'(u_txbegin), 0);
        tick;
        check("t1_beg_n2", 32'(u_txbegin), 1);
        check("t1_data", 32'(u_txdata), 'h55);
        check("t1_cnt0", 32'(tx_count), 0);
        tick;
        check("t1_beg_n3", 32'(u_txbegin), 0);
        check("t1_notidle", 32'(tx_idle), 0);
        wait_idle("t1_idle", 40);
        exp_q = '{8'h55};
        cmp_txq("t1_txq");

        // overflow with stalled transmitter
        txq.delete();
        exp_q.delete();
        stall = 1'b1;
        tick;
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(i);
            wr_stb = 1'b1;
            if (i < 16) exp_q.push_back(8'(i));
            tick;
        end
        wr_stb = 1'b0;
        check("t2_cnt16", 32'(tx_count), 16);
        check("t2_ovf", 32'(tx_ovf), 1);
        busy_len = 2;
        stall = 1'b0;
        wait_idle("t2_idle", 400);
        cmp_txq("t2_txq");
        check("t2_ovf_sticky", 32'(tx_ovf), 1);
        tx_clr = 1'b1;
        tick;
        tx_clr = 1'b0;
        check("t2_ovf_clr", 32'(tx_ovf), 0);

        // push and pop in the same cycle at full
        txq.delete();
        exp_q.delete();
        stall = 1'b1;
        tick;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'('h20 + i);
            exp_q.push_back(8'('h20 + i));
            wr_stb = 1'b1;
            tick;
        end
        wr_stb = 1'b0;
        check("t5_cnt16", 32'(tx_count), 16);
        stall = 1'b0;
        for (int i = 0; i < 20 && u_txbusy; i++) tick;
        check("t5_busy_fell", 32'(u_txbusy), 0);
        write('hEE);
        exp_q.push_back('hEE);
        check("t5_begin", 32'(u_txbegin), 1);
        check("t5_cnt_kept", 32'(tx_count), 16);
        check("t5_no_ovf", 32'(tx_ovf), 0);
        wait_idle("t5_idle", 400);
        cmp_txq("t5_txq");

        // randomized burst against a 16-deep queue model
        for (int r = 0; r < 3; r++) begin
            txq.delete();
            exp_q.delete();
            stall = 1'b1;
            tick;
            k = $urandom_range(1, 20);
            for (int i = 0; i < k; i++) begin
                wr_data = 8'($urandom);
                if (i < 16) exp_q.push_back(wr_data);
                wr_stb = 1'b1;
                tick;
            end
            wr_stb = 1'b0;
            check("rt_cnt", 32'(tx_count), k > 16 ? 16 : k);
            check("rt_ovf", 32'(tx_ovf), k > 16 ? 1 : 0);
            busy_len = $urandom_range(0, 5);
            stall = 1'b0;
            wait_idle("rt_idle", 600);
            cmp_txq("rt_txq");
            tx_clr = 1'b1;
            tick;
            tx_clr = 1'b0;
        end

        // start never acknowledged: byte dropped, FSM returns to idle
        tx_dead = 1'b1;
        write('h99);
        wait_begin("to_begin");
        tick;
        check("to_waiting", 32'(tx_idle), 0);
        repeat (5) tick;
        check("to_idle", 32'(tx_idle), 1);
        check("to_cnt", 32'(tx_count), 0);
        tx_dead = 1'b0;

        // three received bytes, show-ahead reads, underflow
        rxm.delete();
        for (int i = 0; i < 3; i++) begin
            send(8'('hA1 + i));
            rxm.push_back(8'('hA1 + i));
            check("t3_drd", 32'(u_data_read), 1);
            tick;
            check("t3_drd_end", 32'(u_data_read), 0);
        end
        check("t3_cnt", 32'(rx_count), 3);
        for (int i = 0; i < 3; i++) pop("t3_rd");
        check("t3_empty", 32'(rd_data), 'hFF);
        check("t3_unf0", 32'(rx_unf), 0);
        rd_stb = 1'b1;
        tick;
        rd_stb = 1'b0;
        check("t3_unf1", 32'(rx_unf), 1);
        check("t3_cnt0", 32'(rx_count), 0);
        rx_clr = 1'b1;
        tick;
        rx_clr = 1'b0;
        check("t3_unf_clr", 32'(rx_unf), 0);

        // fill to 16, 17th byte held until a pop frees a slot
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            rxm.push_back(b);
            send(b);
            check("t4_drd", 32'(u_data_read), 1);
            check("t4_hiw", 32'(rx_hiwater), i + 1 >= 12 ? 1 : 0);
            tick;
        end
        send('h77);
        check("t4_hold_drd", 32'(u_data_read), 0);
        repeat (3) tick;
        check("t4_hold_drd2", 32'(u_data_read), 0);
        check("t4_cnt16", 32'(rx_count), 16);
        pop("t4_rd_first");
        rxm.push_back('h77);
        check("t4_drd_after_pop", 32'(u_data_read), 1);
        check("t4_cnt_kept", 32'(rx_count), 16);
        tick;
        check("t4_drd_once", 32'(u_data_read), 0);
        while (rxm.size() > 0) pop("t4_rd");
        check("t4_empty", 32'(rd_data), 'hFF);

        // randomized receive/read interleaving against a queue model
        for (int it = 0; it < 40; it++) begin
            bit s, p;
            s = $urandom_range(0, 1) == 1 && rxm.size() < 16;
            p = $urandom_range(0, 1) == 1 && rxm.size() > 0;
            b = 8'($urandom);
            if (p) check("rr_rd", 32'(rd_data), 32'(rxm.pop_front()));
            u_rxdata = b;
            u_rxrecv = s;
            rd_stb = p;
            tick;
            u_rxrecv = 1'b0;
            rd_stb = 1'b0;
            if (s) rxm.push_back(b);
            check("rr_cnt", 32'(rx_count), 32'(rxm.size()));
            check("rr_drd", 32'(u_data_read), 32'(s));
            check("rr_hiw", 32'(rx_hiwater), rxm.size() >= 12 ? 1 : 0);
            tick;
        end
        while (rxm.size() > 0) pop("rr_drain");

        // reset while in T_BUSY and R_HOLD
        txq.delete();
        busy_len = 60;
        write('h3C);
        wait_begin("t6_begin");
        tick;
        write('h01);
        write('h02);
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            tick;
        end
        send('hAA);
        check("t6_held", 32'(u_data_read), 0);
        check("t6_busy", 32'(u_txbusy), 1);
        rst = 1'b1;
        tick;
        check("t6_txc", 32'(tx_count), 0);
        check("t6_rxc", 32'(rx_count), 0);
        check("t6_flags", 32'({tx_ovf, rx_unf, rx_hiwater, u_txbegin, u_data_read}), 0);
        check("t6_txdata", 32'(u_txdata), 0);
        check("t6_rddata", 32'(rd_data), 'hFF);
        rst = 1'b0;
        tick;
        check("t6_drd_pulse", 32'(u_data_read), 1);
        tick;
        check("t6_drd_end", 32'(u_data_read), 0);
        check("t6_notidle", 32'(tx_idle), 0);
        write('hC3);
        wait_idle("t6_idle", 200);
        exp_q = '{8'h3C, 8'hC3};
        cmp_txq("t6_txq");

        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end
endmodule
